// File: rtl/booth_radix4_mult_if.sv
// Request/result bundle for the radix-4 Booth multiplier.
// The master drives the operands; the slave returns Product and status.
interface booth_radix4_mult_if #(
   parameter int unsigned W = 8
);
   logic             start;
   logic             tc;
   logic [W-1:0]     A;
   logic [W-1:0]     B;
   logic [2*W-1:0]   Product;
   logic             busy;
   logic             done;

   modport master (output start, tc, A, B, input  Product, busy, done);
   modport slave  (input  start, tc, A, B, output Product, busy, done);
endinterface

// File: rtl/booth_radix4_mult.sv
// Sequential radix-4 Booth multiplier, signed or unsigned operands.
// Retires one Booth digit per cycle and produces a 2W-bit product.
module booth_radix4_mult #(
   parameter int unsigned W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   booth_radix4_mult_if.slave  bus
);
   localparam int unsigned XW = W + 2;          // extended operand width
   localparam int unsigned N  = W / 2 + 1;      // Booth steps per operation
   localparam int unsigned AW = 2 * XW + 1;     // {upper, multiplier, b[-1]}
   localparam int unsigned CW = $clog2(N);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [XW-1:0]    r_m;
   logic [AW-1:0]    r_acc;
   logic [2*W-1:0]   r_product;
   logic             r_busy;
   logic             r_done;

   logic [XW-1:0]    w_a_ext;
   logic [XW-1:0]    w_b_ext;
   logic [XW-1:0]    w_m2;
   logic [XW-1:0]    w_pp;
   logic [XW-1:0]    w_sum;
   logic [AW-1:0]    w_next;

   // Operand extension, digit selection and one Booth step
   always_comb begin
      w_a_ext = bus.tc ? {{2{bus.A[W-1]}}, bus.A} : {2'b00, bus.A};
      w_b_ext = bus.tc ? {{2{bus.B[W-1]}}, bus.B} : {2'b00, bus.B};
      w_m2    = {r_m[XW-2:0], 1'b0};
      w_pp    = '0;
      case (r_acc[2:0])
         3'b001, 3'b010: w_pp = r_m;
         3'b011:         w_pp = w_m2;
         3'b100:         w_pp = ~w_m2 + XW'(1);
         3'b101, 3'b110: w_pp = ~r_m + XW'(1);
         default:        w_pp = '0;
      endcase
      w_sum  = r_acc[AW-1:XW+1] + w_pp;
      w_next = $unsigned($signed({w_sum, r_acc[XW:0]}) >>> 2);
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_m       <= '0;
         r_acc     <= '0;
         r_product <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_m     <= w_a_ext;
                  r_acc   <= {XW'(0), w_b_ext, 1'b0};
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            S_RUN: begin
               r_acc <= w_next;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CW'(N - 1)) begin
                  r_product <= w_next[2*W:1];
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_state   <= S_DONE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.Product = r_product;
   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
endmodule
